// File: rtl/alu_mc_pkg.sv
// Shared op-codes, FSM/iteration enums and op classification for the multi-cycle ALU.
// Optional divider support is selected by the ALU_MC_DIV_EN macro.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Which value of the iteration datapath is the final answer
    typedef enum logic [1:0] {
        IT_MUL = 2'd0,
        IT_QUO = 2'd1,
        IT_REM = 2'd2
    } iter_mode_e;

    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MULU);
`endif
    endfunction

    function automatic iter_mode_e iter_mode(input logic [3:0] op);
        iter_mode_e m;
        case (op)
            OP_DIVU: m = IT_QUO;
            OP_REMU: m = IT_REM;
            default: m = IT_MUL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the EX-stage controller (master) and the ALU (slave).
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;
    logic             valid_o;

    modport slave (
        input  valid_i, src1_i, src2_i, ctrl_i,
        output ready_o, result_o, zero_o, overflow_o, valid_o
    );

    modport master (
        output valid_i, src1_i, src2_i, ctrl_i,
        input  ready_o, result_o, zero_o, overflow_o, valid_o
    );
endinterface

// File: rtl/alu_mc_iter.sv
// Shared shift/add-subtract iteration datapath: LSB-first shift-add multiply and,
// with ALU_MC_DIV_EN, restoring divide reusing the same adder and registers.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic             i_run,
    input  iter_mode_e       i_mode,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    output logic             o_last,
    output logic [WIDTH-1:0] o_step_result
);

    // r_acc: product accumulator / partial remainder; r_a: multiplier / dividend->quotient
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    iter_mode_e       r_mode;

    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_a;
    logic [WIDTH-1:0] w_step_b;

`ifdef ALU_MC_DIV_EN
    logic             w_div;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;

    assign w_div       = (r_mode != IT_MUL);
    assign w_rem_shift = {r_acc, r_a[WIDTH-1]};
    // Divide reuses the adder as rem - divisor (invert + carry-in)
    assign w_add_a     = w_div ? w_rem_shift[WIDTH-1:0] : r_acc;
    assign w_add_b     = w_div ? ~r_b : (r_a[0] ? r_b : '0);
    assign w_sum       = w_add_a + w_add_b + {{(WIDTH-1){1'b0}}, w_div};
    assign w_ge        = (w_rem_shift >= {1'b0, r_b});

    assign w_step_acc  = (!w_div || w_ge) ? w_sum : w_rem_shift[WIDTH-1:0];
    assign w_step_a    = w_div ? {r_a[WIDTH-2:0], w_ge} : (r_a >> 1);
    assign w_step_b    = w_div ? r_b : (r_b << 1);
`else
    assign w_step_acc  = r_acc + (r_a[0] ? r_b : '0);
    assign w_step_a    = r_a >> 1;
    assign w_step_b    = r_b << 1;
`endif

    assign o_last        = (r_cnt == CNT_W'(1));
    assign o_step_result = (r_mode == IT_QUO) ? w_step_a : w_step_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_mode <= IT_MUL;
        end else if (i_start) begin
            r_acc  <= '0;
            r_a    <= i_src1;
            r_b    <= i_src2;
            r_cnt  <= CNT_W'(WIDTH);
            r_mode <= i_mode;
        end else if (i_run) begin
            r_acc  <= w_step_acc;
            r_a    <= w_step_a;
            r_b    <= w_step_b;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: 1-cycle logic/arith ops plus iterative MULU,
// and DIVU/REMU when ALU_MC_DIV_EN is defined (otherwise those codes act as unknown ops).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    alu_mc_if.slave bus
);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_ovf;

    logic             w_load;
    logic [WIDTH-1:0] w_next_result;
    logic             w_next_ovf;
    logic             w_iter_start;
    logic             w_iter_run;
    logic             w_iter_last;
    iter_mode_e       w_iter_mode;
    logic [WIDTH-1:0] w_iter_result;

    assign w_sum       = bus.src1_i + bus.src2_i;
    assign w_diff      = bus.src1_i - bus.src2_i;
    assign w_slt       = ($signed(bus.src1_i) < $signed(bus.src2_i));
    assign w_iter_mode = iter_mode(bus.ctrl_i);

    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (bus.ctrl_i)
            OP_AND: w_alu_result = bus.src1_i & bus.src2_i;
            OP_OR:  w_alu_result = bus.src1_i | bus.src2_i;
            OP_NOR: w_alu_result = ~(bus.src1_i | bus.src2_i);
            OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                               (w_diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_next_result = '0;
        w_next_ovf    = 1'b0;
        w_iter_start  = 1'b0;
        w_iter_run    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.valid_i) begin
                    if (is_multicycle(bus.ctrl_i)) begin
                        w_iter_start = 1'b1;
`ifdef ALU_MC_DIV_EN
                        w_state_next = (w_iter_mode == IT_MUL) ? MUL : DIV;
`else
                        w_state_next = MUL;
`endif
                    end else begin
                        w_load        = 1'b1;
                        w_next_result = w_alu_result;
                        w_next_ovf    = w_alu_ovf;
                        w_state_next  = DONE;
                    end
                end
            end
            MUL, DIV: begin
                w_iter_run = 1'b1;
                // Final iteration's result is registered on the edge that enters DONE
                if (w_iter_last) begin
                    w_load        = 1'b1;
                    w_next_result = w_iter_result;
                    w_state_next  = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_result <= w_next_result;
                r_zero   <= (w_next_result == '0);
                r_ovf    <= w_next_ovf;
            end
        end
    end

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_start       (w_iter_start),
        .i_run         (w_iter_run),
        .i_mode        (w_iter_mode),
        .i_src1        (bus.src1_i),
        .i_src2        (bus.src2_i),
        .o_last        (w_iter_last),
        .o_step_result (w_iter_result)
    );

    assign bus.ready_o    = (r_state == IDLE);
    assign bus.valid_o    = (r_state == DONE);
    assign bus.result_o   = r_result;
    assign bus.zero_o     = r_zero;
    assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32): directed corner cases plus random ops against an
// arithmetic reference model; divider expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic [31:0]  due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the op definitions, using wide integer arithmetic
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic ovf, output logic multi);
        longint sa;
        longint sb_v;
        longint wide;
        logic [63:0] prod;
        sa   = $signed(a);
        sb_v = $signed(b);
        res   = '0;
        ovf   = 1'b0;
        multi = 1'b0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin
                res  = a + b;
                wide = sa + sb_v;
                ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0110: begin
                res  = a - b;
                wide = sa - sb_v;
                ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0111: res = (sa < sb_v) ? 32'd1 : 32'd0;
            4'b1100: res = ~(a | b);
            4'b1000: begin
                prod  = 64'(a) * 64'(b);
                res   = prod[W-1:0];
                multi = 1'b1;
            end
`ifdef ALU_MC_DIV_EN
            4'b1001: begin
                res   = (b == 0) ? {W{1'b1}} : a / b;
                multi = 1'b1;
            end
            4'b1010: begin
                res   = (b == 0) ? a : a % b;
                multi = 1'b1;
            end
`endif
            default: res = '0;
        endcase
    endfunction

    // Present a request (valid held until accepted) and push its expected response.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic use_x, input logic [W-1:0] xres, input logic xovf,
                         output int acc_edge);
        int   n;
        int   start;
        exp_t e;
        logic [W-1:0] mres;
        logic movf;
        logic multi;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        n = 0;
        while (!bus.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=busy required=ready op=%b", op);
            acc_edge = -1;
            return;
        end
        start = cyc;
        @(posedge clk);
        model(op, a, b, mres, movf, multi);
        e.res = use_x ? xres : mres;
        e.ovf = use_x ? xovf : movf;
        e.due = 32'(start + 1 + (multi ? W : 0));
        sb.push_back(e);
        acc_edge = start + 1;
        $display("issue op=%b a=%h b=%h exp=%h ovf=%0b accept_edge=%0d", op, a, b, e.res, e.ovf, acc_edge);
    endtask

    task automatic quiet(input int n);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = {W{1'b1}};
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: ready_o must match "nothing outstanding"; each valid_o pops one expectation.
    exp_t         mon_e;
    logic [W-1:0] last_res = '0;
    logic         last_zero = 1'b1;
    logic         last_ovf = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            last_res  = '0;
            last_zero = 1'b1;
            last_ovf  = 1'b0;
        end else begin
            chk("ready_o", 32'(bus.ready_o), 32'(sb.size() == 0));
            if (bus.valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result_o", bus.result_o, mon_e.res);
                    chk("zero_o", 32'(bus.zero_o), 32'(mon_e.res == '0));
                    chk("overflow_o", 32'(bus.overflow_o), 32'(mon_e.ovf));
                    chk("latency_cycle", 32'(cyc), mon_e.due);
                    $display("done cycle=%0d result=%h zero=%0b ovf=%0b", cyc, bus.result_o, bus.zero_o, bus.overflow_o);
                    last_res  = mon_e.res;
                    last_zero = (mon_e.res == '0);
                    last_ovf  = mon_e.ovf;
                end
            end else begin
                chk("held_result", bus.result_o, last_res);
                chk("held_zero", 32'(bus.zero_o), 32'(last_zero));
                chk("held_ovf", 32'(bus.overflow_o), 32'(last_ovf));
            end
        end
    end

    logic [3:0] op_tab [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1100, 4'b1000, 4'b1001, 4'b1010};

    initial begin
        int t1;
        int t2;
        logic [3:0] op;
        bus.valid_i = 1'b0;
        bus.ctrl_i  = 4'b0000;
        bus.src1_i  = '0;
        bus.src2_i  = '0;

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_zero", 32'(bus.zero_o), 32'd1);
        chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed corner cases
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 1'b1, t1);
        issue(4'b0110, 32'd5, 32'd5, 1'b1, 32'h0, 1'b0, t1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h1, 1'b0, t1);
        issue(4'b1100, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, t1);
        issue(4'b0011, 32'h1234, 32'h5678, 1'b1, 32'h0, 1'b0, t1);

        // Back-to-back: AND held valid right behind an ADD
        issue(4'b0010, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, t1);
        issue(4'b0000, 32'hF0F0_FFFF, 32'h0FF0_F00F, 1'b1, 32'h00F0_F00F, 1'b0, t2);
        chk("b2b_accept_gap", 32'(t2 - t1), 32'd2);

        // MULU with a request held during the whole operation
        issue(4'b1000, 32'hFFFF_FFFF, 32'd3, 1'b1, 32'hFFFF_FFFD, 1'b0, t1);
        issue(4'b0001, 32'h0000_0F00, 32'h0000_00F0, 1'b1, 32'h0000_0FF0, 1'b0, t2);
        chk("mul_busy_gap", 32'(t2 - t1), 32'(W + 2));

`ifdef ALU_MC_DIV_EN
        issue(4'b1001, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, t1);
        issue(4'b1010, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0, t1);
        issue(4'b1001, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, t1);
        issue(4'b1010, 32'd9, 32'd0, 1'b1, 32'd9, 1'b0, t1);
`else
        issue(4'b1001, 32'd100, 32'd7, 1'b1, 32'd0, 1'b0, t1);
        issue(4'b1010, 32'd100, 32'd7, 1'b1, 32'd0, 1'b0, t1);
        issue(4'b1001, 32'd9, 32'd0, 1'b1, 32'd0, 1'b0, t1);
`endif
        quiet(3);

        // Random traffic against the model
        for (int i = 0; i < 120; i++) begin
            op = (i % 10 == 9) ? 4'($urandom_range(0, 15)) : op_tab[$urandom_range(0, 8)];
            issue(op, rnd_operand(), rnd_operand(), 1'b0, '0, 1'b0, t1);
            if ($urandom_range(0, 3) == 0) quiet(int'($urandom_range(1, 3)));
        end
        quiet(2);
        drain();

        // Reset during MULU after 10 iterations: aborts with no valid_o
        issue(4'b0010, 32'h1234, 32'h1, 1'b1, 32'h1235, 1'b0, t1);
        quiet(2);
        drain();
        issue(4'b1000, $urandom, $urandom, 1'b0, '0, 1'b0, t1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.ready_o), 32'd1);
        chk("abort_valid", 32'(bus.valid_o), 32'd0);
        chk("abort_result", bus.result_o, 32'd0);
        chk("abort_zero", 32'(bus.zero_o), 32'd1);
        chk("abort_ovf", 32'(bus.overflow_o), 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        quiet(40);

        issue(4'b0110, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, t1);
        quiet(3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; successor to the single-cycle 32-bit ALU in the CPU datapath.
- Adds a WIDTH parameter, a valid/ready handshake, an overflow flag, and iterative unsigned multiply/divide/remainder.
- Sits in the EX stage of the multi-cycle CPU; the controller stalls while `ready_o` is low.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  operation code.
- result_o  output  WIDTH  registered result, held until the next completion.
- zero_o  output  1  result_o == 0, registered alongside result_o.
- overflow_o  output  1  signed overflow for ADD/SUB; 0 for every other op.
- valid_o  output  1  one-cycle pulse: result_o/zero_o/overflow_o updated.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - result_o=0, zero_o=1, overflow_o=0, valid_o=0, ready_o=1.
  - Counter and internal operand registers cleared.
  - Reset mid-operation aborts the operation; no valid_o is produced for it.
- ctrl_i encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
  - 1000 MULU (low WIDTH bits of the product), 1001 DIVU (quotient), 1010 REMU (remainder).
  - Any other code: result 0, completes as a 1-cycle op.
- Accept: valid_i && ready_o at a rising edge; ctrl_i and both operands are captured at that edge.
- ready_o = (state==IDLE). valid_i while not ready is ignored; no queuing.
- States:
  - IDLE: on accept of a 1-cycle op, go to DONE with the result computed from the captured operands; on accept of MULU/DIVU/REMU, go to MUL or DIV and load count=WIDTH.
  - MUL: shift-add, one multiplier bit per cycle, count decrements; when count==1, go to DONE.
  - DIV: restoring division, one quotient bit per cycle; when count==1, go to DONE.
  - DONE: valid_o=1 for this cycle only; result_o/flags already registered; next state IDLE, so ready_o is 0 in DONE.
- Latency (accept edge = t0):
  - 1-cycle ops: valid_o high in the cycle after t0.
  - MULU/DIVU/REMU: valid_o high in the cycle after edge t0+WIDTH.
  - Throughput for 1-cycle ops: one accept every 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; overflow_o = operand signs equal (SUB: B inverted) and result sign differs.
  - SLT: result = {WIDTH-1 zeros, signed A<B}, computed without overflow error.
  - MULU truncates to the low WIDTH bits; no overflow flag.
- Divide by zero: DIVU returns all-ones, REMU returns src1 (natural restoring-division result); full latency, no flag.
- result_o, zero_o, overflow_o change only on the edge that enters DONE.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: DIV state and divider datapath present; DIVU/REMU behave as above.
- Undefined: no divider logic; DIVU/REMU are treated as unknown codes (1-cycle, result 0, zero_o=1).

Decomposition:
- Package alu_mc_pkg: 4-bit op-code localparams (OP_AND…OP_REMU), state enum (IDLE, MUL, DIV, DONE), function `is_multicycle(op)`.
- One sub-module: alu_mc_iter, the shared shift/add-subtract iteration datapath (accumulator, operand shift registers, counter). The top-level FSM drives it with start/mode and reads its last-step result.

Test Plan (WIDTH=32):
- Reset asserted during MUL after 10 iterations -> immediate IDLE, ready_o=1, result_o=0, zero_o=1; no valid_o pulse.
- ADD 0x7FFFFFFF + 1 -> valid_o 1 cycle after accept, result 0x80000000, overflow_o=1, zero_o=0. SUB 5-5 -> result 0, zero_o=1, overflow_o=0.
- SLT 0xFFFFFFFF vs 1 -> result 1. NOR 0 with 0 -> result 0xFFFFFFFF.
- MULU 0xFFFFFFFF × 3 -> valid_o in the cycle after edge t0+32, result 0xFFFFFFFD; ready_o low from t0 until IDLE; a valid_i mid-operation is ignored.
- DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9 (with ALU_MC_DIV_EN). Without the macro: DIVU -> 0, 1-cycle latency.
- Back-to-back: ADD accepted, then AND presented continuously -> AND accepted on the edge after DONE; exactly one valid_o per operation.
